// File: rtl/ula_sequencer.sv
// Command-side sequencer for the 8-bit ULA: accepts one request, drives the ULA,
// waits LATENCY edges, captures the result and returns it over a valid/ready handshake.
module ula_sequencer #(
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic [7:0]  ula_a,
   output logic [7:0]  ula_b,
   output logic [2:0]  ula_opcode,
   input  logic [7:0]  ula_s,
   input  logic        ula_flag,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_s,
   output logic        rsp_flag,
   output logic        rsp_zero,
   output logic [2:0]  rsp_op,
   output logic [15:0] op_count
);

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned COUNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic                 cmd_ready_next, rsp_valid_next;
   logic [DATA_W-1:0]    ula_a_next, ula_b_next, rsp_s_next;
   logic [OP_W-1:0]      ula_opcode_next, rsp_op_next;
   logic                 rsp_flag_next, rsp_zero_next;
   logic [COUNT_W-1:0]   op_count_next;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         ula_a      <= '0;
         ula_b      <= '0;
         ula_opcode <= '0;
         rsp_s      <= '0;
         rsp_flag   <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_op     <= '0;
         op_count   <= '0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         cmd_ready  <= cmd_ready_next;
         rsp_valid  <= rsp_valid_next;
         ula_a      <= ula_a_next;
         ula_b      <= ula_b_next;
         ula_opcode <= ula_opcode_next;
         rsp_s      <= rsp_s_next;
         rsp_flag   <= rsp_flag_next;
         rsp_zero   <= rsp_zero_next;
         rsp_op     <= rsp_op_next;
         op_count   <= op_count_next;
      end
   end

   // Next state and next register values; everything holds unless changed below
   always_comb begin
      state_next      = state;
      cnt_next        = cnt;
      cmd_ready_next  = 1'b0;
      rsp_valid_next  = rsp_valid;
      ula_a_next      = ula_a;
      ula_b_next      = ula_b;
      ula_opcode_next = ula_opcode;
      rsp_s_next      = rsp_s;
      rsp_flag_next   = rsp_flag;
      rsp_zero_next   = rsp_zero;
      rsp_op_next     = rsp_op;
      op_count_next   = op_count;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               ula_a_next      = cmd_a;
               ula_b_next      = cmd_b;
               ula_opcode_next = cmd_op;
               rsp_op_next     = cmd_op;
               cnt_next        = CNT_W'(LATENCY);
               state_next      = WAIT;
            end else begin
               cmd_ready_next = 1'b1;
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) begin
               rsp_s_next     = ula_s;
               rsp_flag_next  = ula_flag;
               rsp_zero_next  = (ula_s == DATA_W'(0));
               rsp_valid_next = 1'b1;
               state_next     = RESP;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               op_count_next  = op_count + COUNT_W'(1);
               rsp_valid_next = 1'b0;
               cmd_ready_next = 1'b1;
               state_next     = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
